// File: rtl/sub_serial_framed.sv
// Bit-serial two's-complement subtractor (c = a - b), LSB first, framed into
// N-bit words with an input valid handshake, a bit counter and a final
// borrow flag that reports unsigned a < b for the completed word.
//
// state | meaning
// IDLE  | waiting for start & in_valid; the borrow chain is reset for bit 0
// RUN   | word in progress; each in_valid beat consumes one bit

module sub_serial_framed #(
    parameter int N     = 256,
    parameter int CNT_W = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic in_valid,
    input  logic a,
    input  logic b,
    output logic c,
    output logic c_valid,
    output logic busy,
    output logic done,
    output logic borrow_out
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             borrow;

    logic bi;
    logic d;
    logic bo;
    logic accept;
    logic last;

    // One-bit full subtractor; the borrow-in is forced to zero on bit 0 so a
    // back-to-back word never inherits the previous word's borrow.
    always_comb begin
        bi     = (state == RUN) ? borrow : 1'b0;
        d      = a ^ b ^ bi;
        bo     = (~a & b) | (~(a ^ b) & bi);
        accept = in_valid & ((state == IDLE) ? start : 1'b1);
        last   = (state == RUN) && (cnt == CNT_W'(N - 1));
    end

    // Word FSM with registered outputs; c holds its last value between beats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            borrow     <= 1'b0;
            c          <= 1'b0;
            c_valid    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            borrow_out <= 1'b0;
        end else begin
            c_valid <= 1'b0;
            done    <= 1'b0;
            if (accept) begin
                c       <= d;
                c_valid <= 1'b1;
                borrow  <= bo;
                if (state == IDLE) begin
                    state <= RUN;
                    busy  <= 1'b1;
                    cnt   <= CNT_W'(1);
                end else if (last) begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    cnt        <= '0;
                    done       <= 1'b1;
                    borrow_out <= bo;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sub_serial_framed.sv
// Scoreboard bench for sub_serial_framed: a 4-bit instance for the directed
// cases and a 256-bit instance for randomized words with random stalls.
// Expected words come from plain wide arithmetic, not from a bit-level model.

module tb_sub_serial_framed;

    typedef struct {
        logic [255:0] diff;
        logic         brw;
        int           cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [1:0] start_i;
    logic [1:0] inv_i;
    logic [1:0] a_i;
    logic [1:0] b_i;
    logic [1:0] c_o;
    logic [1:0] cv_o;
    logic [1:0] busy_o;
    logic [1:0] done_o;
    logic [1:0] bo_o;

    int checks;
    int errors;
    int cyc;

    exp_t q0[$];
    exp_t q1[$];

    int           bcnt[2];
    logic [255:0] wrd[2];

    localparam int NUM_RAND = 150;

    sub_serial_framed #(.N(4), .CNT_W(3)) dut4 (
        .clk(clk), .rst(rst), .start(start_i[0]), .in_valid(inv_i[0]),
        .a(a_i[0]), .b(b_i[0]), .c(c_o[0]), .c_valid(cv_o[0]),
        .busy(busy_o[0]), .done(done_o[0]), .borrow_out(bo_o[0])
    );

    sub_serial_framed #(.N(256), .CNT_W(9)) dut256 (
        .clk(clk), .rst(rst), .start(start_i[1]), .in_valid(inv_i[1]),
        .a(a_i[1]), .b(b_i[1]), .c(c_o[1]), .c_valid(cv_o[1]),
        .busy(busy_o[1]), .done(done_o[1]), .borrow_out(bo_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: assemble c bits per instance and compare against the scoreboard on done.
    initial begin
        exp_t e;
        bcnt[0] = 0; bcnt[1] = 0;
        wrd[0] = '0; wrd[1] = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                bcnt[0] = 0; bcnt[1] = 0;
                wrd[0] = '0; wrd[1] = '0;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (cv_o[k]) begin
                        if (bcnt[k] < 256) wrd[k][bcnt[k]] = c_o[k];
                        bcnt[k]++;
                    end
                    if (done_o[k]) begin
                        chk("done_with_c_valid", 256'(cv_o[k]), 256'd1);
                        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                            chk("done_unexpected", 256'(done_o[k]), 256'd0);
                        end else begin
                            if (k == 0) e = q0.pop_front();
                            else        e = q1.pop_front();
                            chk("c_word", wrd[k], e.diff);
                            chk("borrow_out", 256'(bo_o[k]), 256'(e.brw));
                            chk("done_cycle", 256'(cyc), 256'(e.cyc));
                            chk("bit_count", 256'(bcnt[k]), (k == 0) ? 256'd4 : 256'd256);
                        end
                        bcnt[k] = 0;
                        wrd[k]  = '0;
                    end
                end
            end
        end
    end

    task automatic idle(input int k, input bit start_noise);
        @(posedge clk); #1;
        inv_i[k]   = 1'b0;
        start_i[k] = start_noise;
        a_i[k]     = 1'($urandom_range(1));
        b_i[k]     = 1'($urandom_range(1));
    endtask

    // Drive one word; the last bit is left on the inputs so a following call
    // starts the next word with no bubble.
    task automatic drive_word(input int k, input logic [255:0] av, input logic [255:0] bv,
                              input int gap_pct, input int stall_at, input int stall_len,
                              input bit mid_start);
        int           n;
        int           g;
        logic [255:0] mask;
        exp_t         e;
        n    = (k == 0) ? 4 : 256;
        mask = (k == 0) ? 256'hF : {256{1'b1}};
        av   = av & mask;
        bv   = bv & mask;
        for (int i = 0; i < n; i++) begin
            g = (i == stall_at) ? stall_len : 0;
            if (i > 0 && gap_pct > 0 && $urandom_range(99) < gap_pct) g = $urandom_range(3, 1);
            for (int s = 0; s < g; s++) begin
                @(posedge clk); #1;
                inv_i[k]   = 1'b0;
                start_i[k] = 1'($urandom_range(1));
                a_i[k]     = 1'($urandom_range(1));
                b_i[k]     = 1'($urandom_range(1));
            end
            @(posedge clk); #1;
            if (k == 0 && i == 1) chk("busy_in_word", 256'(busy_o[0]), 256'd1);
            inv_i[k]   = 1'b1;
            start_i[k] = (i == 0) || (mid_start && i == 2);
            a_i[k]     = av[i];
            b_i[k]     = bv[i];
            if (i == n - 1) begin
                e.diff = (av - bv) & mask;
                e.brw  = (av < bv);
                e.cyc  = cyc + 1;
                if (k == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
    endtask

    initial begin
        logic [255:0] ra;
        logic [255:0] rb;
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        rst     = 1'b0;
        start_i = '0;
        inv_i   = '0;
        a_i     = '0;
        b_i     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 256'({c_o, cv_o, busy_o, done_o, bo_o}), 256'd0);
        rst = 1'b1;

        // Directed cases on the 4-bit instance.
        drive_word(0, 256'd5, 256'd3, 0, -1, 0, 1'b0);
        idle(0, 1'b0);
        chk("done_after_last", 256'(done_o[0]), 256'd1);
        chk("busy_after_last", 256'(busy_o[0]), 256'd0);
        idle(0, 1'b1);
        idle(0, 1'b0);
        chk("start_without_valid_ignored", 256'(busy_o[0]), 256'd0);

        drive_word(0, 256'd3, 256'd5, 0, -1, 0, 1'b0);
        idle(0, 1'b0);
        drive_word(0, 256'd9, 256'd9, 0, -1, 0, 1'b0);
        idle(0, 1'b0);

        drive_word(0, 256'd5, 256'd3, 0, 2, 2, 1'b0);
        idle(0, 1'b0);

        drive_word(0, 256'd3, 256'd5, 0, -1, 0, 1'b0);
        drive_word(0, 256'd5, 256'd3, 0, -1, 0, 1'b1);
        idle(0, 1'b0);
        idle(0, 1'b0);

        // Reset in the middle of a word.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            inv_i[0]   = 1'b1;
            start_i[0] = (i == 0);
            a_i[0]     = 1'((5 >> i) & 1);
            b_i[0]     = 1'((3 >> i) & 1);
        end
        @(posedge clk); #1;
        inv_i[0]   = 1'b0;
        start_i[0] = 1'b0;
        chk("pre_reset_c_valid", 256'(cv_o[0]), 256'd1);
        rst = 1'b0;
        #1;
        chk("midword_reset_outputs", 256'({c_o[0], cv_o[0], busy_o[0], done_o[0], bo_o[0]}), 256'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        drive_word(0, 256'd5, 256'd3, 0, -1, 0, 1'b0);
        idle(0, 1'b0);

        // Randomized words on the 256-bit instance.
        for (int w = 0; w < NUM_RAND; w++) begin
            for (int j = 0; j < 8; j++) begin
                ra[j*32 +: 32] = $urandom();
                rb[j*32 +: 32] = $urandom();
            end
            if ($urandom_range(7) == 0) rb = ra;
            if ($urandom_range(15) == 0) begin
                ra = '0;
                rb = {256{1'b1}};
            end
            drive_word(1, ra, rb, 10, -1, 0, 1'b0);
            if ($urandom_range(1) == 1) begin
                for (int s = 0; s < int'($urandom_range(2, 1)); s++) idle(1, 1'($urandom_range(1)));
            end
        end
        idle(1, 1'b0);

        for (int t = 0; t < 20 && (q0.size() != 0 || q1.size() != 0); t++) @(posedge clk);
        #1;
        chk("scoreboard_drained", 256'(q0.size() + q1.size()), 256'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
